// File: rtl/aes_inv_cipher_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// aes_inv_cipher_iter: iterative AES-128 decryption, one inverse round per clock.
// Rev 1.0 -- define AES_INV_CIPHER_OVERLAP_EN to overlap output consume with next accept.
// ---------------------------------------------------------------------------

module inv_mix_col (
  input  logic [0:31] col,
  output logic [0:31] mixed
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [7:0] x1, x2, x4, x8;
    assign x1    = col[8*r +: 8];
    assign x2    = xt(x1);
    assign x4    = xt(x2);
    assign x8    = xt(x4);
    assign m9[r] = x8 ^ x1;
    assign mb[r] = x8 ^ x2 ^ x1;
    assign md[r] = x8 ^ x4 ^ x1;
    assign me[r] = x8 ^ x4 ^ x2;
  end

  for (genvar r = 0; r < 4; r++) begin : g_out
    assign mixed[8*r +: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
  end
endmodule

module aes_inv_cipher_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] inp_matrix,
  output logic [3:0]   rk_idx,
  input  logic [0:127] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_matrix
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[8*b +: 8];
  endfunction

  // Byte (r,c) of the result comes from byte (r,(c-r) mod 4) of the input, then InvSubBytes.
  function automatic logic [0:127] inv_shift_sub(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = inv_sbox(s[8*(4*((c-r+4)%4)+r) +: 8]);
      end
    end
    return o;
  endfunction

  fsm_e         fsm, fsm_next;
  logic [3:0]   rnd;
  logic [0:127] state;
  logic [0:127] ark;
  logic [0:127] mixed;
  logic         accept;

  assign ark    = inv_shift_sub(state) ^ rk_data;
  assign accept = in_valid && in_ready;

  for (genvar c = 0; c < 4; c++) begin : g_col
    inv_mix_col u_imc (
      .col   (ark[32*c +: 32]),
      .mixed (mixed[32*c +: 32])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    in_ready = 1'b0;
    rk_idx   = 4'd0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        rk_idx   = 4'd10;
        if (in_valid) fsm_next = ROUND;
      end
      ROUND: begin
        rk_idx = rnd;
        if (rnd == 4'd1) fsm_next = FINAL;
      end
      FINAL: begin
        rk_idx   = 4'd0;
        fsm_next = DONE;
      end
      DONE: begin
`ifdef AES_INV_CIPHER_OVERLAP_EN
        in_ready = out_ready;
        rk_idx   = 4'd10;
        if (out_ready) fsm_next = in_valid ? ROUND : IDLE;
`else
        rk_idx = 4'd0;
        if (out_ready) fsm_next = IDLE;
`endif
      end
      default: fsm_next = IDLE;
    endcase
  end

  // accept can only be true in IDLE or DONE, so it never collides with a round update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= '0;
      rnd        <= 4'd0;
      out_valid  <= 1'b0;
      out_matrix <= '0;
    end else begin
      if (accept) begin
        state <= inp_matrix ^ rk_data;
        rnd   <= 4'd9;
      end else if (fsm == ROUND) begin
        state <= mixed;
        rnd   <= rnd - 4'd1;
      end
      if (fsm == FINAL) begin
        out_matrix <= ark;
        out_valid  <= 1'b1;
      end else if (fsm == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_aes_inv_cipher_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_aes_inv_cipher_iter: directed FIPS-197 vectors with a key-schedule model on rk_data.
// Rev 1.0 -- expectations follow AES_INV_CIPHER_OVERLAP_EN when defined.
// ---------------------------------------------------------------------------

module tb_aes_inv_cipher_iter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:127] inp_matrix = '0;
  logic [3:0]   rk_idx;
  logic [0:127] rk_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [0:127] out_matrix;

  always #5 clk = ~clk;

  aes_inv_cipher_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inp_matrix (inp_matrix),
    .rk_idx     (rk_idx),
    .rk_data    (rk_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_matrix (out_matrix)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  logic [127:0] rk_tab [0:10];
  logic [7:0]   sbox [0:255];
  int           errors = 0;
  int           checks = 0;

`ifdef AES_INV_CIPHER_OVERLAP_EN
  localparam int SPACING = 11;
`else
  localparam int SPACING = 12;
`endif

  assign rk_data = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : 128'h0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return gmul_ret(p);
  endfunction

  function automatic logic [7:0] gmul_ret(input logic [7:0] p);
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One block with out_ready held high; checks latency, plaintext and the rk_idx sequence.
  task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] pt);
    logic [3:0] seq [0:10];
    int off;
    for (int i = 0; i < 11; i++) seq[i] = 4'hf;
    off = 0;
    while (!in_ready && off < 30) begin tick(); off++; end
    check({tag, "_idle_ready"}, {127'h0, in_ready}, 128'h1);
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    inp_matrix = ct;
    seq[0] = rk_idx;
    tick();
    in_valid   = 1'b0;
    inp_matrix = {$urandom, $urandom, $urandom, $urandom};
    off = 0;
    while (!out_valid && off < 20) begin
      if (off < 10) seq[off+1] = rk_idx;
      tick();
      off++;
    end
    check({tag, "_latency"}, 128'(off), 128'd10);
    check({tag, "_plaintext"}, out_matrix, pt);
    for (int i = 0; i < 11; i++)
      check($sformatf("%s_rk_idx[%0d]", tag, i), {124'h0, seq[i]}, 128'(10 - i));
    tick();
    check({tag, "_consumed"}, {127'h0, out_valid}, 128'h0);
  endtask

  vec_t vecs [2];

  initial begin
    int off, n_acc, cyc;
    int acc [0:3];
    logic [127:0] pt_c1;

    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt:  128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct:  128'h3925841d02dc09fbdc118597196a0b32,
                pt:  128'h3243f6a8885a308d313198a2e0370734};
    pt_c1 = vecs[0].pt;

    build_sbox();
    set_key(vecs[0].key);

    // Asynchronous reset, checked before the first clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready",   {127'h0, in_ready},  128'h1);
    check("rst_rk_idx",     {124'h0, rk_idx},    128'd10);
    check("rst_out_valid",  {127'h0, out_valid}, 128'h0);
    check("rst_out_matrix", out_matrix,          128'h0);
    tick(); tick();
    #3 rst_n = 1'b1;

    for (int v = 0; v < 2; v++) begin
      set_key(vecs[v].key);
      run_block($sformatf("vec%0d", v), vecs[v].ct, vecs[v].pt);
    end

    // Backpressure with in_valid pulses during busy and DONE.
    set_key(vecs[0].key);
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    inp_matrix = vecs[0].ct;
    tick();
    off = 0;
    while (!out_valid && off < 20) begin
      in_valid   = off[0];
      inp_matrix = {$urandom, $urandom, $urandom, $urandom};
      out_ready  = 1'($urandom_range(0, 1));
      tick();
      off++;
    end
    check("bp_latency", 128'(off), 128'd10);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid   = 1'b1;
      inp_matrix = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check($sformatf("bp_out_valid[%0d]", i),  {127'h0, out_valid}, 128'h1);
      check($sformatf("bp_out_matrix[%0d]", i), out_matrix,          pt_c1);
      check($sformatf("bp_in_ready[%0d]", i),   {127'h0, in_ready},  128'h0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_released_valid", {127'h0, out_valid}, 128'h0);
    check("bp_released_ready", {127'h0, in_ready},  128'h1);

    // Reset while in ROUND with rnd=5, then a clean block.
    in_valid   = 1'b1;
    inp_matrix = vecs[0].ct;
    tick();
    in_valid = 1'b0;
    off = 0;
    while (rk_idx != 4'd5 && off < 20) begin tick(); off++; end
    check("midrst_reach_rnd5", {124'h0, rk_idx}, 128'd5);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid",  {127'h0, out_valid}, 128'h0);
    check("midrst_out_matrix", out_matrix,          128'h0);
    check("midrst_in_ready",   {127'h0, in_ready},  128'h1);
    check("midrst_rk_idx",     {124'h0, rk_idx},    128'd10);
    tick(); tick();
    #3 rst_n = 1'b1;
    run_block("after_rst", vecs[0].ct, vecs[0].pt);

    // Back-to-back with in_valid and out_ready held high.
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    inp_matrix = vecs[0].ct;
    n_acc = 0;
    cyc   = 0;
    for (int i = 0; i < 60 && n_acc < 4; i++) begin
      if (out_valid) check($sformatf("b2b_out[%0d]", cyc), out_matrix, pt_c1);
      if (in_valid && in_ready) begin acc[n_acc] = cyc; n_acc++; end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("b2b_accepts", 128'(n_acc), 128'd4);
    for (int i = 1; i < 4; i++)
      if (i < n_acc) check($sformatf("b2b_spacing[%0d]", i), 128'(acc[i] - acc[i-1]), 128'(SPACING));
    off = 0;
    while (!(in_ready && !out_valid) && off < 30) begin
      if (out_valid) check("b2b_drain_out", out_matrix, pt_c1);
      tick();
      off++;
    end
    check("b2b_drained", {127'h0, in_ready && !out_valid}, 128'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule

`default_nettype wire
